// File: rtl/adder_mmio_pkg.sv
// Shared register map and STATUS layout for the adder MMIO front-end.
package adder_mmio_pkg;

  typedef enum logic [3:0] {
    ADDR_STATUS = 4'h0,
    ADDR_X      = 4'h4,
    ADDR_Y      = 4'h8,
    ADDR_RESULT = 4'hC
  } reg_addr_e;

  localparam int unsigned STAT_PENDING   = 0;
  localparam int unsigned STAT_BUSY      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_FULL      = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;
  localparam int unsigned STAT_COUNT_W   = 3;
  localparam int unsigned STAT_ERR       = 7;

  function automatic logic [7:0] pack_status(
    input logic                    pending,
    input logic                    busy,
    input logic                    empty,
    input logic                    full,
    input logic [STAT_COUNT_W-1:0] count,
    input logic                    err
  );
    logic [7:0] s;
    s                                   = '0;
    s[STAT_PENDING]                     = pending;
    s[STAT_BUSY]                        = busy;
    s[STAT_EMPTY]                       = empty;
    s[STAT_FULL]                        = full;
    s[STAT_COUNT_LSB +: STAT_COUNT_W]   = count;
    s[STAT_ERR]                         = err;
    return s;
  endfunction

endpackage

// File: rtl/adder_mmio_result_fifo.sv
// Synchronous result FIFO; head data is combinational, count spans 0..DEPTH.
module adder_mmio_result_fifo
  import adder_mmio_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Guards make the FIFO safe even if a caller ignores full/empty.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/adder_mmio_driver.sv
// MMIO front-end: software-written operands are issued to the accelerator,
// and returned results are buffered for software to pop via RESULT reads.
module adder_mmio_driver
  import adder_mmio_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reg_wr_en,
  input  logic             reg_rd_en,
  input  logic [3:0]       reg_addr,
  input  logic [WIDTH-1:0] reg_wdata,
  output logic [WIDTH-1:0] reg_rdata,
  output logic             reg_rd_valid,
  output logic             acc_input_valid,
  input  logic             acc_input_ready,
  output logic [WIDTH-1:0] acc_x,
  output logic [WIDTH-1:0] acc_y,
  input  logic             acc_output_valid,
  output logic             acc_output_ready,
  input  logic [WIDTH-1:0] acc_result,
  input  logic             acc_busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_pending;
  logic             r_err;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rd_valid;

  logic             w_issue;
  logic             w_wr_status;
  logic             w_wr_x;
  logic             w_wr_y;
  logic             w_load_ok;
  logic             w_y_drop;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [WIDTH-1:0] w_head;
  logic [7:0]       w_status8;
  logic [WIDTH-1:0] w_rd_mux;

  assign acc_input_valid  = r_pending;
  assign acc_x            = r_x;
  assign acc_y            = r_y;
  assign acc_output_ready = !w_full;
  assign reg_rdata        = r_rdata;
  assign reg_rd_valid     = r_rd_valid;

  assign w_issue     = r_pending && acc_input_ready;
  assign w_wr_status = reg_wr_en && (reg_addr == ADDR_STATUS);
  assign w_wr_x      = reg_wr_en && (reg_addr == ADDR_X);
  assign w_wr_y      = reg_wr_en && (reg_addr == ADDR_Y);
  // Operands may only change when no request is outstanding, or on the very
  // edge that completes the handshake (the accelerator samples the old values).
  assign w_load_ok   = !r_pending || w_issue;
  assign w_y_drop    = w_wr_y && !w_load_ok;

  assign w_push = acc_output_valid && acc_output_ready;
  assign w_pop  = reg_rd_en && (reg_addr == ADDR_RESULT) && !w_empty;

  adder_mmio_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (acc_result),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign w_status8 = pack_status(r_pending, acc_busy, w_empty, w_full,
                                 STAT_COUNT_W'(w_count), r_err);

  always_comb begin
    w_rd_mux = '0;
    case (reg_addr)
      ADDR_STATUS: w_rd_mux = {{(WIDTH-8){1'b0}}, w_status8};
      ADDR_X:      w_rd_mux = r_x;
      ADDR_Y:      w_rd_mux = r_y;
      ADDR_RESULT: w_rd_mux = w_empty ? '0 : w_head;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_pending  <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_x && w_load_ok) begin
        r_x <= reg_wdata;
      end
      if (w_wr_y && w_load_ok) begin
        r_y       <= reg_wdata;
        r_pending <= 1'b1;
      end else if (w_issue) begin
        r_pending <= 1'b0;
      end

      if (w_y_drop) begin
        r_err <= 1'b1;
      end else if (w_wr_status && reg_wdata[STAT_ERR]) begin
        r_err <= 1'b0;
      end

      r_rd_valid <= reg_rd_en;
      if (reg_rd_en) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_adder_mmio_driver.sv
// Directed self-checking bench for adder_mmio_driver (WIDTH=32, DEPTH=4).
module tb_adder_mmio_driver;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic         clock;
  logic         reset;
  logic         reg_wr_en;
  logic         reg_rd_en;
  logic [3:0]   reg_addr;
  logic [W-1:0] reg_wdata;
  logic [W-1:0] reg_rdata;
  logic         reg_rd_valid;
  logic         acc_input_valid;
  logic         acc_input_ready;
  logic [W-1:0] acc_x;
  logic [W-1:0] acc_y;
  logic         acc_output_valid;
  logic         acc_output_ready;
  logic [W-1:0] acc_result;
  logic         acc_busy;

  int total = 0;
  int bad   = 0;

  adder_mmio_driver #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .reg_wr_en        (reg_wr_en),
    .reg_rd_en        (reg_rd_en),
    .reg_addr         (reg_addr),
    .reg_wdata        (reg_wdata),
    .reg_rdata        (reg_rdata),
    .reg_rd_valid     (reg_rd_valid),
    .acc_input_valid  (acc_input_valid),
    .acc_input_ready  (acc_input_ready),
    .acc_x            (acc_x),
    .acc_y            (acc_y),
    .acc_output_valid (acc_output_valid),
    .acc_output_ready (acc_output_ready),
    .acc_result       (acc_result),
    .acc_busy         (acc_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  // All tasks start and end on a negative clock edge.
  task automatic do_write(input logic [3:0] a, input logic [W-1:0] d);
    reg_wr_en = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clock);
    reg_wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [W-1:0] d, output logic v);
    reg_rd_en = 1'b1;
    reg_addr  = a;
    @(negedge clock);
    reg_rd_en = 1'b0;
    d = reg_rdata;
    v = reg_rd_valid;
  endtask

  task automatic push_result(input logic [W-1:0] r);
    acc_output_valid = 1'b1;
    acc_result       = r;
    @(negedge clock);
    acc_output_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    logic         v;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    total++; if (reg_rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0h exp=0", reg_rd_valid); end
    total++; if (reg_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", reg_rdata); end
    total++; if (acc_input_valid !== 1'b0) begin bad++; $display("FAIL rst_in_valid got=%0h exp=0", acc_input_valid); end
    total++; if (acc_output_ready !== 1'b1) begin bad++; $display("FAIL rst_out_ready got=%0h exp=1", acc_output_ready); end
    total++; if (acc_x !== '0 || acc_y !== '0) begin bad++; $display("FAIL rst_xy got=%0h/%0h exp=0/0", acc_x, acc_y); end
    do_read(4'h0, d, v);
    total++; if (d !== 32'h04 || v !== 1'b1) begin bad++; $display("FAIL rst_status got=%0h v=%0b exp=04 v=1", d, v); end
  endtask

  task automatic test_basic();
    logic [W-1:0] d;
    logic         v;
    acc_input_ready = 1'b1;
    do_write(4'h4, 32'd12);
    do_write(4'h8, 32'd30);
    total++; if (acc_input_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", acc_input_valid); end
    total++; if (acc_x !== 32'd12 || acc_y !== 32'd30) begin bad++; $display("FAIL basic_xy got=%0d/%0d exp=12/30", acc_x, acc_y); end
    @(negedge clock);
    total++; if (acc_input_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%0b exp=0", acc_input_valid); end
    push_result(32'd42);
    do_read(4'h0, d, v);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL basic_status1 got=%0h exp=10", d); end
    do_read(4'hC, d, v);
    total++; if (d !== 32'd42 || v !== 1'b1) begin bad++; $display("FAIL basic_result got=%0d v=%0b exp=42 v=1", d, v); end
    do_read(4'h0, d, v);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL basic_status2 got=%0h exp=04", d); end
    do_read(4'h4, d, v);
    total++; if (d !== 32'd12) begin bad++; $display("FAIL read_x got=%0d exp=12", d); end
    do_read(4'h8, d, v);
    total++; if (d !== 32'd30) begin bad++; $display("FAIL read_y got=%0d exp=30", d); end
    do_write(4'h1, 32'hDEAD);
    do_read(4'h4, d, v);
    total++; if (d !== 32'd12) begin bad++; $display("FAIL unmapped_wr got=%0d exp=12", d); end
    do_read(4'h2, d, v);
    total++; if (d !== 32'd0 || v !== 1'b1) begin bad++; $display("FAIL unmapped_rd got=%0h exp=0", d); end
  endtask

  task automatic test_err();
    logic [W-1:0] d;
    logic         v;
    acc_input_ready = 1'b0;
    do_write(4'h8, 32'd100);
    do_write(4'h8, 32'd200);
    total++; if (acc_y !== 32'd100) begin bad++; $display("FAIL err_y_kept got=%0d exp=100", acc_y); end
    do_read(4'h0, d, v);
    total++; if (d !== 32'h85) begin bad++; $display("FAIL err_status got=%0h exp=85", d); end
    do_write(4'h0, 32'h80);
    do_read(4'h0, d, v);
    total++; if (d !== 32'h05) begin bad++; $display("FAIL err_clear got=%0h exp=05", d); end
    acc_input_ready = 1'b1;
    @(negedge clock);
    total++; if (acc_input_valid !== 1'b0) begin bad++; $display("FAIL err_issue got=%0b exp=0", acc_input_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic         v;
    acc_input_ready = 1'b1;
    do_write(4'h8, 32'd5);
    do_write(4'h8, 32'd6);
    total++; if (acc_input_valid !== 1'b1 || acc_y !== 32'd6) begin bad++; $display("FAIL b2b_y got=%0b/%0d exp=1/6", acc_input_valid, acc_y); end
    @(negedge clock);
    do_read(4'h0, d, v);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL b2b_status got=%0h exp=04", d); end
  endtask

  task automatic test_fifo_full();
    logic [W-1:0] d;
    logic         v;
    for (int i = 1; i <= 4; i++) push_result(W'(i));
    total++; if (acc_output_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", acc_output_ready); end
    acc_output_valid = 1'b1;
    acc_result       = 32'd5;
    do_read(4'h0, d, v);
    total++; if (d !== 32'h48) begin bad++; $display("FAIL full_status got=%0h exp=48", d); end
    do_read(4'hC, d, v);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL full_pop1 got=%0d exp=1", d); end
    total++; if (acc_output_ready !== 1'b1) begin bad++; $display("FAIL full_freed got=%0b exp=1", acc_output_ready); end
    @(negedge clock);
    acc_output_valid = 1'b0;
    total++; if (acc_output_ready !== 1'b0) begin bad++; $display("FAIL full_refill got=%0b exp=0", acc_output_ready); end
    for (int i = 2; i <= 5; i++) begin
      do_read(4'hC, d, v);
      total++; if (d !== W'(i)) begin bad++; $display("FAIL full_order got=%0d exp=%0d", d, i); end
    end
    do_read(4'h0, d, v);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL full_drained got=%0h exp=04", d); end
  endtask

  task automatic test_empty_read();
    logic [W-1:0] d;
    logic         v;
    do_read(4'hC, d, v);
    total++; if (d !== 32'd0 || v !== 1'b1) begin bad++; $display("FAIL empty_rd got=%0h v=%0b exp=0 v=1", d, v); end
    do_read(4'h0, d, v);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL empty_status got=%0h exp=04", d); end
  endtask

  task automatic test_push_pop();
    logic [W-1:0] d;
    logic         v;
    push_result(32'd7);
    acc_output_valid = 1'b1;
    acc_result       = 32'd8;
    do_read(4'hC, d, v);
    acc_output_valid = 1'b0;
    total++; if (d !== 32'd7) begin bad++; $display("FAIL pp_pop got=%0d exp=7", d); end
    do_read(4'h0, d, v);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL pp_count got=%0h exp=10", d); end
    do_read(4'hC, d, v);
    total++; if (d !== 32'd8) begin bad++; $display("FAIL pp_second got=%0d exp=8", d); end
  endtask

  task automatic test_busy_hold();
    logic [W-1:0] d;
    logic         v;
    acc_busy = 1'b1;
    do_read(4'h0, d, v);
    acc_busy = 1'b0;
    total++; if (d !== 32'h06) begin bad++; $display("FAIL busy_status got=%0h exp=06", d); end
    repeat (2) @(negedge clock);
    total++; if (reg_rd_valid !== 1'b0 || reg_rdata !== 32'h06) begin bad++; $display("FAIL rdata_hold got=%0h v=%0b exp=06 v=0", reg_rdata, reg_rd_valid); end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] d;
    logic         v;
    acc_input_ready = 1'b0;
    do_write(4'h8, 32'd9);
    do_write(4'h8, 32'd10);
    push_result(32'd11);
    push_result(32'd12);
    reset            = 1'b0;
    acc_input_ready  = 1'b1;
    acc_output_valid = 1'b1;
    acc_result       = 32'd13;
    @(negedge clock);
    reset            = 1'b1;
    acc_output_valid = 1'b0;
    acc_input_ready  = 1'b0;
    total++; if (acc_input_valid !== 1'b0 || acc_y !== '0) begin bad++; $display("FAIL mrst_issue got=%0b/%0d exp=0/0", acc_input_valid, acc_y); end
    total++; if (acc_output_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%0b exp=1", acc_output_ready); end
    do_read(4'h0, d, v);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL mrst_status got=%0h exp=04", d); end
  endtask

  initial begin
    reset            = 1'b0;
    reg_wr_en        = 1'b0;
    reg_rd_en        = 1'b0;
    reg_addr         = '0;
    reg_wdata        = '0;
    acc_input_ready  = 1'b0;
    acc_output_valid = 1'b0;
    acc_result       = '0;
    acc_busy         = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_err();
    test_back_to_back();
    test_fifo_full();
    test_empty_read();
    test_push_pop();
    test_busy_hold();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
